// File: rtl/bus_interconnect_if.sv
// rtl/bus_interconnect_if.sv - CPU memory port and slave fan-out bundle for bus_interconnect
interface bus_interconnect_if #(
    parameter int NUM_SLAVES = 3,
    parameter int DATA_W     = 32
);
    logic [31:0]                   m_address;
    logic                          m_rw_req;
    logic                          m_rw;
    logic [DATA_W-1:0]             m_write_data;
    logic [1:0]                    m_size;
    logic [DATA_W-1:0]             m_read_data;
    logic                          m_rec;
    logic [31:0]                   s_address;
    logic                          s_rw;
    logic [DATA_W-1:0]             s_write_data;
    logic [1:0]                    s_size;
    logic [NUM_SLAVES-1:0]         s_rw_req;
    logic [NUM_SLAVES*DATA_W-1:0]  s_read_data;
    logic [NUM_SLAVES-1:0]         s_rec;

    // Interconnect view: serves the CPU, drives the slave fan-out
    modport slave (
        input  m_address, m_rw_req, m_rw, m_write_data, m_size,
        output m_read_data, m_rec,
        output s_address, s_rw, s_write_data, s_size, s_rw_req,
        input  s_read_data, s_rec
    );

    modport master (
        output m_address, m_rw_req, m_rw, m_write_data, m_size,
        input  m_read_data, m_rec,
        input  s_address, s_rw, s_write_data, s_size, s_rw_req,
        output s_read_data, s_rec
    );
endinterface

// File: rtl/bus_interconnect.sv
// rtl/bus_interconnect.sv - address-decoding interconnect with timeout and error response
module bus_interconnect #(
    parameter int                         NUM_SLAVES = 3,
    parameter int                         DATA_W     = 32,
    parameter logic [NUM_SLAVES*32-1:0]   SLAVE_BASE = {32'h80000000, 32'h00000000, 32'h00000000},
    parameter logic [NUM_SLAVES*32-1:0]   SLAVE_MASK = {32'h80000000, 32'h80000000, 32'hFFFF0000},
    parameter int                         TIMEOUT    = 1024,
    parameter logic [DATA_W-1:0]          ERR_DATA   = 32'hDEADBEEF
) (
    input  logic                   mclk,
    input  logic                   reset,
    bus_interconnect_if.slave      bus,
    output logic                   bus_err,
    output logic                   err_sticky,
    output logic [31:0]            err_addr,
    input  logic                   err_clear,
    output logic [NUM_SLAVES-1:0]  sel
);
    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] TO_SAT  = CNT_W'((TIMEOUT > 0) ? TIMEOUT : 1);

    typedef enum logic [1:0] {IDLE, BUSY, ERR, DONE} state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  cnt;
    logic              hit;
    logic [IDX_W-1:0]  hit_idx;

    // Scan downward so the lowest matching slave is the one left standing
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((bus.m_address & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            idx              <= '0;
            cnt              <= '0;
            bus.m_read_data  <= '0;
            bus.m_rec        <= 1'b0;
            bus.s_address    <= '0;
            bus.s_rw         <= 1'b0;
            bus.s_write_data <= '0;
            bus.s_size       <= '0;
            bus.s_rw_req     <= '0;
            bus_err          <= 1'b0;
            err_sticky       <= 1'b0;
            err_addr         <= '0;
            sel              <= '0;
        end else begin
            bus.m_rec <= 1'b0;
            bus_err   <= 1'b0;
            // Placed before the ERR branch so a same-cycle error keeps the flag set
            if (err_clear) err_sticky <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.m_rw_req) begin
                        bus.s_address    <= bus.m_address;
                        bus.s_rw         <= bus.m_rw;
                        bus.s_write_data <= bus.m_write_data;
                        bus.s_size       <= bus.m_size;
                        cnt              <= '0;
                        if (hit) begin
                            idx          <= hit_idx;
                            bus.s_rw_req <= NUM_SLAVES'(1) << hit_idx;
                            sel          <= NUM_SLAVES'(1) << hit_idx;
                            state        <= BUSY;
                        end else begin
                            state <= ERR;
                        end
                    end
                end
                BUSY: begin
                    if (!bus.m_rw_req) begin
                        bus.s_rw_req <= '0;
                        sel          <= '0;
                        state        <= IDLE;
                    end else if (bus.s_rec[idx]) begin
                        bus.m_read_data <= bus.s_read_data[idx*DATA_W +: DATA_W];
                        bus.m_rec       <= 1'b1;
                        bus.s_rw_req    <= '0;
                        state           <= DONE;
                    end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
                        bus.s_rw_req <= '0;
                        state        <= ERR;
                    end else if (cnt != TO_SAT) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ERR: begin
                    bus.m_read_data <= ERR_DATA;
                    bus.m_rec       <= 1'b1;
                    bus_err         <= 1'b1;
                    err_sticky      <= 1'b1;
                    err_addr        <= bus.s_address;
                    state           <= DONE;
                end
                DONE: begin
                    if (!bus.m_rw_req) begin
                        sel   <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_interconnect.sv
// tb/tb_bus_interconnect.sv - directed self-checking bench for bus_interconnect
module tb_bus_interconnect;
    logic        mclk;
    logic        reset;
    logic        a_bus_err, a_err_sticky, a_err_clear;
    logic [31:0] a_err_addr;
    logic [2:0]  a_sel;
    logic        b_bus_err, b_err_sticky, b_err_clear;
    logic [31:0] b_err_addr;
    logic [1:0]  b_sel;
    int          total;
    int          bad;

    bus_interconnect_if #(.NUM_SLAVES(3), .DATA_W(32)) ia ();
    bus_interconnect_if #(.NUM_SLAVES(2), .DATA_W(32)) ib ();

    bus_interconnect #(.NUM_SLAVES(3), .TIMEOUT(16)) dut_a (
        .mclk(mclk), .reset(reset), .bus(ia.slave),
        .bus_err(a_bus_err), .err_sticky(a_err_sticky), .err_addr(a_err_addr),
        .err_clear(a_err_clear), .sel(a_sel)
    );

    bus_interconnect #(
        .NUM_SLAVES(2),
        .SLAVE_BASE({32'h00000000, 32'h00000000}),
        .SLAVE_MASK({32'h80000000, 32'hFFFF0000})
    ) dut_b (
        .mclk(mclk), .reset(reset), .bus(ib.slave),
        .bus_err(b_bus_err), .err_sticky(b_err_sticky), .err_addr(b_err_addr),
        .err_clear(b_err_clear), .sel(b_sel)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    // Request on dut_a; selected slave answers after lat wait cycles while
    // the other slaves spam s_rec, then the request is held through DONE.
    task automatic xfer_a(input string tag, input logic [31:0] addr, input logic rw,
                          input logic [31:0] wd, input int slv, input int lat,
                          input logic [31:0] rd);
        logic [2:0] oh;
        oh = 3'b001 << slv;
        ia.m_address    = addr;
        ia.m_rw         = rw;
        ia.m_write_data = wd;
        ia.m_size       = 2'd2;
        ia.s_read_data  = {32'hBAD20002, 32'hBAD10001, 32'hBAD00000};
        ia.s_read_data[slv*32 +: 32] = rd;
        ia.m_rw_req     = 1'b1;
        tick();
        chk({tag, "_req"}, ia.s_rw_req, oh);
        chk({tag, "_sel"}, a_sel, oh);
        chk({tag, "_addr"}, ia.s_address, addr);
        chk({tag, "_rw"}, ia.s_rw, rw);
        chk({tag, "_wd"}, ia.s_write_data, wd);
        chk({tag, "_size"}, ia.s_size, 2'd2);
        for (int i = 0; i < lat; i++) begin
            ia.s_rec = ~oh;
            tick();
            chk({tag, "_wait_rec"}, ia.m_rec, 1'b0);
            chk({tag, "_wait_req"}, ia.s_rw_req, oh);
        end
        ia.s_rec = oh;
        tick();
        ia.s_rec = 3'b000;
        chk({tag, "_rec"}, ia.m_rec, 1'b1);
        chk({tag, "_berr"}, a_bus_err, 1'b0);
        chk({tag, "_rdata"}, ia.m_read_data, rd);
        chk({tag, "_req_drop"}, ia.s_rw_req, 3'b000);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk({tag, "_held_rec"}, ia.m_rec, 1'b0);
            chk({tag, "_held_req"}, ia.s_rw_req, 3'b000);
        end
        ia.m_rw_req = 1'b0;
        tick();
        chk({tag, "_hold_data"}, ia.m_read_data, rd);
        chk({tag, "_sel_idle"}, a_sel, 3'b000);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        a_err_clear = 1'b0;
        b_err_clear = 1'b0;
        ia.m_address = '0; ia.m_rw_req = 1'b0; ia.m_rw = 1'b0; ia.m_write_data = '0;
        ia.m_size = '0; ia.s_read_data = '0; ia.s_rec = '0;
        ib.m_address = '0; ib.m_rw_req = 1'b0; ib.m_rw = 1'b0; ib.m_write_data = '0;
        ib.m_size = '0; ib.s_read_data = '0; ib.s_rec = '0;
        tick();
        tick();
        chk("rst_rec", ia.m_rec, 1'b0);
        chk("rst_req", ia.s_rw_req, 3'b000);
        chk("rst_rdata", ia.m_read_data, 32'h0);
        chk("rst_saddr", ia.s_address, 32'h0);
        chk("rst_sticky", a_err_sticky, 1'b0);
        chk("rst_erraddr", a_err_addr, 32'h0);
        reset = 1'b1;
        tick();

        xfer_a("rd0", 32'h00000100, 1'b0, 32'h0, 0, 3, 32'h12345678);
        xfer_a("rd1", 32'h00020000, 1'b0, 32'h0, 1, 1, 32'hCAFEF00D);
        xfer_a("wr2", 32'h80000004, 1'b1, 32'h00000055, 2, 0, 32'h00000077);
        xfer_a("rd2", 32'h80000004, 1'b0, 32'h0, 2, 2, 32'h00000055);
        // s_rec lands on the same edge the timeout would expire
        xfer_a("race", 32'h00000008, 1'b0, 32'h0, 0, 15, 32'h600DDA7A);

        // Timeout on slave 1 with err_clear held high: set must win
        a_err_clear  = 1'b1;
        ia.m_address = 32'h00040000;
        ia.m_rw      = 1'b0;
        ia.m_rw_req  = 1'b1;
        tick();
        chk("to_req", ia.s_rw_req, 3'b010);
        for (int i = 1; i <= 16; i++) tick();
        chk("to_norec16", ia.m_rec, 1'b0);
        chk("to_reqdrop", ia.s_rw_req, 3'b000);
        tick();
        chk("to_rec18", ia.m_rec, 1'b1);
        chk("to_berr18", a_bus_err, 1'b1);
        chk("to_rdata", ia.m_read_data, 32'hDEADBEEF);
        chk("to_erraddr", a_err_addr, 32'h00040000);
        chk("to_sticky_setwins", a_err_sticky, 1'b1);
        a_err_clear = 1'b0;
        ia.m_rw_req = 1'b0;
        tick();
        chk("to_rec_pulse", ia.m_rec, 1'b0);
        chk("to_berr_pulse", a_bus_err, 1'b0);
        chk("to_sticky_hold", a_err_sticky, 1'b1);
        a_err_clear = 1'b1;
        tick();
        a_err_clear = 1'b0;
        chk("to_sticky_clr", a_err_sticky, 1'b0);

        // Abort: master drops its request while BUSY
        ia.m_address = 32'h00000010;
        ia.m_rw_req  = 1'b1;
        tick();
        chk("ab_req", ia.s_rw_req, 3'b001);
        ia.m_rw_req = 1'b0;
        tick();
        chk("ab_req_drop", ia.s_rw_req, 3'b000);
        chk("ab_sel", a_sel, 3'b000);
        chk("ab_rec", ia.m_rec, 1'b0);
        tick();
        chk("ab_rec_late", ia.m_rec, 1'b0);
        chk("ab_rdata_hold", ia.m_read_data, 32'hDEADBEEF);

        // Two-slave instance: upper half is unmapped
        ib.m_address = 32'h80000000;
        ib.m_rw_req  = 1'b1;
        tick();
        chk("um_req0", ib.s_rw_req, 2'b00);
        chk("um_rec1", ib.m_rec, 1'b0);
        tick();
        chk("um_rec2", ib.m_rec, 1'b1);
        chk("um_berr2", b_bus_err, 1'b1);
        chk("um_req2", ib.s_rw_req, 2'b00);
        chk("um_rdata", ib.m_read_data, 32'hDEADBEEF);
        chk("um_erraddr", b_err_addr, 32'h80000000);
        ib.m_rw_req = 1'b0;
        tick();
        chk("um_rec3", ib.m_rec, 1'b0);
        chk("um_sticky", b_err_sticky, 1'b1);

        // Asynchronous reset while BUSY
        ia.m_address = 32'h80000100;
        ia.m_rw_req  = 1'b1;
        tick();
        chk("rb_req", ia.s_rw_req, 3'b100);
        #2;
        reset = 1'b0;
        #1;
        chk("rb_req0", ia.s_rw_req, 3'b000);
        chk("rb_sel0", a_sel, 3'b000);
        chk("rb_saddr0", ia.s_address, 32'h0);
        chk("rb_rdata0", ia.m_read_data, 32'h0);
        chk("rb_erraddr0", a_err_addr, 32'h0);
        ia.m_rw_req = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("rb_rec", ia.m_rec, 1'b0);
        chk("rb_idle_req", ia.s_rw_req, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
